tx_pause_sched: RTL
===================

# tx_pause_sched

Transmit flow-control scheduler that decides when the MAC transmit path emits PAUSE frames. It watches the receive-FIFO fill level against XOFF/XON hysteresis thresholds and drives the `xreq`/`xon` request pair of the TX encapsulator, with a handshake closed by `xdone`. While congestion persists it re-sends the XOFF pause before the link partner's pause time expires. It sits between the RX buffer/register block and the TX encapsulator, in the TX clock domain.

## Interface
Parameters:
- `LVL_W`, 12: width of the FIFO level and the threshold buses.
- `XDONE_TO`, 1023: maximum number of cycles `xreq` may wait for `xdone`.

Ports:
- `clk` input 1: TX core clock.
- `rst_` input 1: reset, asynchronous, active-low.
- `pfc_en` input 1: enables pause generation.
- `rxfifo_level` input LVL_W: current RX FIFO occupancy.
- `xoff_thresh` input LVL_W: congestion is entered when level >= this value.
- `xon_thresh` input LVL_W: congestion is exited when level < this value.
- `tx_pause_value` input 16: pause quanta advertised in XOFF frames.
- `qtick` input 1: one-cycle pulse per pause quantum (512 bit times), generated externally.
- `xdone` input 1: one-cycle pulse meaning the pause frame has been sent.
- `xreq` output 1: pause-frame request to the encapsulator.
- `xon` output 1: 1 = send `tx_pause_value` (XOFF frame); 0 = send pause value 0 (resume frame).
- `paused` output 1: scheduler is holding the partner off.
- `xoff_cnt` output 16: XOFF frames sent; saturates at 16'hFFFF.
- `xon_cnt` output 16: resume frames sent; saturates at 16'hFFFF.
- `to_err` output 1: sticky flag, set on `xdone` timeout.

## Operation
- Stage 1 registers two flags: `cong = level >= xoff_thresh` and `clr = level < xon_thresh`.
- If `xon_thresh > xoff_thresh`, `clr` is forced to `!cong` so that the thresholds cannot oscillate.
- `pfc_en_eff = pfc_en && (tx_pause_value != 0)`.
- FSM states are IDLE, SEND_XOFF, HOLD, SEND_XON and GAP.
- IDLE:
  - Go to SEND_XOFF when `pfc_en_eff && cong`.
- SEND_XOFF:
  - `xreq = 1`, `xon = 1`.
  - On `xdone`: increment `xoff_cnt`, load the refresh timer with `tx_pause_value >> 1` (minimum 1), and go to HOLD.
- HOLD:
  - `paused = 1`.
  - The timer decrements on each `qtick` and stops at 0.
  - Priority order:
    1. `!pfc_en_eff` or `clr`: go to SEND_XON.
    2. Timer == 0 and `cong` still set: go to SEND_XOFF (refresh).
    3. Timer == 0 and level between the two thresholds: reload the timer and stay in HOLD (refresh only while level >= `xoff_thresh`).
- SEND_XON:
  - `xreq = 1`, `xon = 0`.
  - On `xdone`: increment `xon_cnt` and go to GAP.
- GAP:
  - One cycle with `xreq = 0`, then go to IDLE.
  - This guarantees at least one low cycle between requests.
- `pfc_en` falling during SEND_XOFF or SEND_XON does not abort the request; the handshake completes and HOLD then resolves it.
- Watchdog: a counter runs while `xreq = 1`. When it reaches `XDONE_TO`:
  - set `to_err`;
  - drop `xreq`;
  - go to GAP without incrementing a counter (a timed-out XOFF goes to GAP, not HOLD).
- `to_err` is cleared only by reset.
- Counters and the watchdog use plain binary arithmetic. Counters saturate rather than wrap.

## Timing
- Reset values: all outputs 0 and FSM in IDLE. The refresh timer, watchdog and stage-1 flags are also 0.
- Level crossing at cycle N: `xreq` rises at N+2 (flag register, then FSM register). `xreq` and `xon` are registered outputs.
- `xon` is stable for the whole time `xreq` is high. It changes only while `xreq = 0`, or on the same edge that `xreq` rises.
- `xdone` at cycle M: `xreq` is low at M+1, the counter has updated at M+1, and `paused` is 1 at M+1 (XOFF case).
- An `xdone` arriving while not in SEND_* is ignored.
- `qtick` coinciding with the timer load: the load wins.
- Reset asserted mid-handshake: `xreq` drops asynchronously. A later stray `xdone` is ignored.

## Structure
- Package `tx_pause_sched_pkg` holds:
  - the one-hot state encoding (5 bits, IDLE = 5'h01);
  - the refresh divisor shift (1);
  - the counter saturation constant.
- Sub-module `tx_pause_refresh_tmr`: 16-bit loadable down-counter with ports load, value, `qtick` and zero. All other logic stays in the top module.

## Test plan
- `tx_pause_value = 16'h0100`, `xoff_thresh = 800`, `xon_thresh = 400`, level steps 0->900 -> `xreq = 1` and `xon = 1` two cycles later; `xdone` -> `xreq` low next cycle, `paused = 1`, `xoff_cnt = 1`.
- Level held at 900 with `qtick` every cycle -> XOFF re-sent after 128 ticks; `xoff_cnt = 2`, `xon_cnt = 0`.
- Level drops to 300 during HOLD -> `xreq = 1` with `xon = 0`; `xdone` -> `paused = 0`, `xon_cnt = 1`, `xreq` low for at least 1 cycle.
- Level 600 (between thresholds) with the timer expiring -> no refresh frame, timer reloads, `paused` stays 1.
- `xdone` never returned -> `xreq` drops after 1023 cycles, `to_err = 1`, counters unchanged.
- `pfc_en` cleared during SEND_XOFF -> XOFF completes on `xdone`, a resume frame (`xon = 0`) follows, FSM ends in IDLE; `tx_pause_value = 0` -> no request ever issued.

Source files
------------

// File: rtl/tx_pause_sched_pkg.sv
// tx_pause_sched shared types and constants.
// One-hot FSM encoding, refresh divisor and counter helpers.
package tx_pause_sched_pkg;

  typedef enum logic [4:0] {
    S_IDLE      = 5'h01,
    S_SEND_XOFF = 5'h02,
    S_HOLD      = 5'h04,
    S_SEND_XON  = 5'h08,
    S_GAP       = 5'h10
  } state_t;

  localparam int          REFRESH_SHIFT = 1;
  localparam logic [15:0] CNT_SAT       = 16'hFFFF;

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v
  );
    return (v == CNT_SAT) ? v : v + 16'd1;
  endfunction

  // Half the advertised pause, so the refresh lands before it expires.
  function automatic logic [15:0] refresh_val(
    input logic [15:0] pv
  );
    logic [15:0] h;
    h = pv >> REFRESH_SHIFT;
    return (h == 16'd0) ? 16'd1 : h;
  endfunction

endpackage

// File: rtl/tx_pause_refresh_tmr.sv
// XOFF refresh timer: loadable 16-bit down-counter
// stepped by pause-quantum ticks, holding at zero.
module tx_pause_refresh_tmr (
  input  logic        clk,
  input  logic        rst_,
  input  logic        load,
  input  logic [15:0] value,
  input  logic        qtick,
  output logic        zero
);

  logic [15:0] cnt_q;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= value;
    end else if (qtick && (cnt_q != 16'd0)) begin
      cnt_q <= cnt_q - 16'd1;
    end
  end

  assign zero = (cnt_q == 16'd0);

endmodule

// File: rtl/tx_pause_sched.sv
// TX PAUSE-frame scheduler: FIFO-level hysteresis drives
// XOFF/XON requests to the encapsulator with refresh and watchdog.
module tx_pause_sched
  import tx_pause_sched_pkg::*;
#(
  parameter int LVL_W    = 12,
  parameter int XDONE_TO = 1023
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             pfc_en,
  input  logic [LVL_W-1:0] rxfifo_level,
  input  logic [LVL_W-1:0] xoff_thresh,
  input  logic [LVL_W-1:0] xon_thresh,
  input  logic [15:0]      tx_pause_value,
  input  logic             qtick,
  input  logic             xdone,
  output logic             xreq,
  output logic             xon,
  output logic             paused,
  output logic [15:0]      xoff_cnt,
  output logic [15:0]      xon_cnt,
  output logic             to_err
);

  localparam int WD_W = $clog2(XDONE_TO + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(XDONE_TO - 1);

  state_t state_q;
  state_t state_n;

  logic            cong_q;
  logic            clr_q;
  logic            cong_d;
  logic            clr_d;
  logic            pfc_en_eff;
  logic            xreq_q;
  logic            xon_q;
  logic            paused_q;
  logic [15:0]     xoff_cnt_q;
  logic [15:0]     xon_cnt_q;
  logic            to_err_q;
  logic [WD_W-1:0] wd_q;
  logic            wd_exp;
  logic            tmr_load;
  logic [15:0]     tmr_val;
  logic            tmr_zero;
  logic            xoff_inc;
  logic            xon_inc;
  logic            to_set;
  logic            send_n;

  // Inverted thresholds collapse to a single level to avoid oscillation.
  always_comb begin
    cong_d = (rxfifo_level >= xoff_thresh);
    if (xon_thresh > xoff_thresh) begin
      clr_d = !cong_d;
    end else begin
      clr_d = (rxfifo_level < xon_thresh);
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      cong_q <= 1'b0;
      clr_q  <= 1'b0;
    end else begin
      cong_q <= cong_d;
      clr_q  <= clr_d;
    end
  end

  assign pfc_en_eff = pfc_en && (tx_pause_value != 16'd0);
  assign wd_exp     = xreq_q && (wd_q == WD_LAST);

  tx_pause_refresh_tmr u_tmr (
    .clk   (clk),
    .rst_  (rst_),
    .load  (tmr_load),
    .value (tmr_val),
    .qtick (qtick),
    .zero  (tmr_zero)
  );

  always_comb begin
    state_n  = state_q;
    tmr_load = 1'b0;
    tmr_val  = refresh_val(tx_pause_value);
    xoff_inc = 1'b0;
    xon_inc  = 1'b0;
    to_set   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pfc_en_eff && cong_q) begin
          state_n = S_SEND_XOFF;
        end
      end
      S_SEND_XOFF: begin
        if (xdone) begin
          xoff_inc = 1'b1;
          tmr_load = 1'b1;
          state_n  = S_HOLD;
        end else if (wd_exp) begin
          to_set  = 1'b1;
          state_n = S_GAP;
        end
      end
      S_HOLD: begin
        if (!pfc_en_eff || clr_q) begin
          state_n = S_SEND_XON;
        end else if (tmr_zero && cong_q) begin
          state_n = S_SEND_XOFF;
        end else if (tmr_zero) begin
          tmr_load = 1'b1;
        end
      end
      S_SEND_XON: begin
        if (xdone) begin
          xon_inc = 1'b1;
          state_n = S_GAP;
        end else if (wd_exp) begin
          to_set  = 1'b1;
          state_n = S_GAP;
        end
      end
      S_GAP: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  assign send_n = (state_n == S_SEND_XOFF) ||
                  (state_n == S_SEND_XON);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q    <= S_IDLE;
      xreq_q     <= 1'b0;
      xon_q      <= 1'b0;
      paused_q   <= 1'b0;
      xoff_cnt_q <= '0;
      xon_cnt_q  <= '0;
      to_err_q   <= 1'b0;
      wd_q       <= '0;
    end else begin
      state_q  <= state_n;
      xreq_q   <= send_n;
      xon_q    <= (state_n == S_SEND_XOFF);
      // Stays paused across a refresh or resume handshake started in HOLD.
      paused_q <= (state_n == S_HOLD) || (paused_q && send_n);
      if (xoff_inc) begin
        xoff_cnt_q <= sat_inc(xoff_cnt_q);
      end
      if (xon_inc) begin
        xon_cnt_q <= sat_inc(xon_cnt_q);
      end
      if (to_set) begin
        to_err_q <= 1'b1;
      end
      if (xreq_q) begin
        wd_q <= wd_q + WD_W'(1);
      end else begin
        wd_q <= '0;
      end
    end
  end

  assign xreq     = xreq_q;
  assign xon      = xon_q;
  assign paused   = paused_q;
  assign xoff_cnt = xoff_cnt_q;
  assign xon_cnt  = xon_cnt_q;
  assign to_err   = to_err_q;

endmodule
